dmem_ctrl: RTL

- Byte-addressed, little-endian data memory controller for the RISC-V core's load/store path. Parametrised successor to the single-cycle data memory.
- Adds:
  - true byte-lane stores (SB/SH/SW);
  - in-block load sign/zero extension (LB/LH/LW/LBU/LHU);
  - valid/ready request and response handshakes with a registered read;
  - out-of-range and illegal-op error reporting;
  - a sequential zero-initialisation sweep after reset, replacing the flop-reset array.
- Sits between the core's memory stage and the AXI4-Lite data-side bridge.

---
 rtl/dmem_ctrl.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/dmem_ctrl.sv
// Byte-addressed little-endian data memory controller with valid/ready handshakes and a zero-init sweep.
// Define DMEM_MISALIGN_CHECK_EN to report misaligned halfword/word accesses as errors instead of force-aligning them.
module dmem_ctrl #(
    parameter int DEPTH_WORDS = 1024,
    parameter int AW          = 32
) (
    input  logic          clk,
    input  logic          mem_reset,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [AW-1:0] req_addr,
    input  logic          req_we,
    input  logic [2:0]    req_funct3,
    input  logic [31:0]   req_wdata,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [31:0]   rsp_rdata,
    output logic          rsp_err,
    output logic          init_done
);

    localparam int                IDX_W      = $clog2(DEPTH_WORDS);
    localparam logic [IDX_W-1:0]  LAST_IDX   = IDX_W'(DEPTH_WORDS - 1);
    localparam logic [AW:0]       ADDR_LIMIT = (AW+1)'(longint'(DEPTH_WORDS) * 4);

    typedef enum logic [1:0] {
        ST_INIT,
        ST_IDLE,
        ST_RESP
    } state_t;

    state_t           state;
    logic [IDX_W-1:0] init_cnt;
    logic [31:0]      mem [DEPTH_WORDS];

    logic             accept;
    logic [IDX_W-1:0] word_idx;
    logic [1:0]       byte_off;
    logic [31:0]      rd_word;
    logic [7:0]       rd_byte;
    logic [15:0]      rd_half;
    logic             addr_oob;
    logic             illegal_op;
    logic             misaligned;
    logic             req_err;
    logic             do_write;
    logic [3:0]       wr_be;
    logic [31:0]      wr_data;
    logic [31:0]      load_data;
    logic [31:0]      rsp_data_next;

    assign req_ready = (state == ST_IDLE) | ((state == ST_RESP) & rsp_ready);
    assign accept    = req_valid & req_ready;

    assign word_idx  = req_addr[IDX_W+1:2];
    assign byte_off  = req_addr[1:0];
    assign rd_word   = mem[word_idx];
    assign rd_byte   = rd_word[{byte_off, 3'b000} +: 8];
    assign rd_half   = req_addr[1] ? rd_word[31:16] : rd_word[15:0];
    assign addr_oob  = {1'b0, req_addr} >= ADDR_LIMIT;

    // Lane enables, replicated store data and extended load data per access size
    always_comb begin
        illegal_op = 1'b0;
        wr_be      = 4'b0000;
        wr_data    = 32'h0;
        load_data  = 32'h0;
        case (req_funct3)
            3'b000: begin
                wr_be     = 4'b0001 << byte_off;
                wr_data   = {4{req_wdata[7:0]}};
                load_data = {{24{rd_byte[7]}}, rd_byte};
            end
            3'b001: begin
                wr_be     = req_addr[1] ? 4'b1100 : 4'b0011;
                wr_data   = {2{req_wdata[15:0]}};
                load_data = {{16{rd_half[15]}}, rd_half};
            end
            3'b010: begin
                wr_be     = 4'b1111;
                wr_data   = req_wdata;
                load_data = rd_word;
            end
            3'b100: begin
                illegal_op = req_we;
                load_data  = {24'h0, rd_byte};
            end
            3'b101: begin
                illegal_op = req_we;
                load_data  = {16'h0, rd_half};
            end
            default: illegal_op = 1'b1;
        endcase
    end

`ifdef DMEM_MISALIGN_CHECK_EN
    assign misaligned = ((req_funct3[1:0] == 2'b01) & req_addr[0]) |
                        ((req_funct3 == 3'b010) & (byte_off != 2'b00));
`else
    assign misaligned = 1'b0;
`endif

    assign req_err       = addr_oob | illegal_op | misaligned;
    assign do_write      = accept & req_we & ~req_err;
    assign rsp_data_next = (req_we | req_err) ? 32'h0 : load_data;

    // Storage has no reset; the INIT sweep is the only thing that clears it
    always_ff @(posedge clk) begin
        if (state == ST_INIT) begin
            mem[init_cnt] <= 32'h0;
        end else if (do_write) begin
            for (int i = 0; i < 4; i++) begin
                if (wr_be[i]) begin
                    mem[word_idx][8*i +: 8] <= wr_data[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge mem_reset) begin
        if (mem_reset) begin
            state     <= ST_INIT;
            init_cnt  <= '0;
            init_done <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'h0;
            rsp_err   <= 1'b0;
        end else begin
            case (state)
                ST_INIT: begin
                    init_cnt <= init_cnt + 1'b1;
                    if (init_cnt == LAST_IDX) begin
                        state     <= ST_IDLE;
                        init_done <= 1'b1;
                    end
                end
                ST_IDLE, ST_RESP: begin
                    if (accept) begin
                        state     <= ST_RESP;
                        rsp_valid <= 1'b1;
                        rsp_rdata <= rsp_data_next;
                        rsp_err   <= req_err;
                    end else if ((state == ST_RESP) && rsp_ready) begin
                        state     <= ST_IDLE;
                        rsp_valid <= 1'b0;
                        rsp_rdata <= 32'h0;
                        rsp_err   <= 1'b0;
                    end
                end
                default: state <= ST_INIT;
            endcase
        end
    end

endmodule
